// File: rtl/carry_select_adder_16.sv
// Registered carry-select adder: {cout,s} = a + b + cin, one cycle of latency.
// Define CSA_RIPPLE_CHECK_EN to add a parallel ripple adder and a registered mismatch flag.
module carry_select_adder_16 #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef CSA_RIPPLE_CHECK_EN
    ,
    output logic             mismatch
`endif
);

    localparam int NBLK = WIDTH / BLOCK;

    if (WIDTH % BLOCK != 0) begin : g_width_check
        $error("carry_select_adder_16: WIDTH must be a multiple of BLOCK");
    end

    // Full-adder ripple over one block; returns {carry_out, sum}.
    function automatic logic [BLOCK:0] ripple_blk(input logic [BLOCK-1:0] x,
                                                  input logic [BLOCK-1:0] y,
                                                  input logic             c);
        logic [BLOCK-1:0] acc;
        logic             cc;
        cc = c;
        for (int i = 0; i < BLOCK; i++) begin
            acc[i] = x[i] ^ y[i] ^ cc;
            cc     = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
        end
        return {cc, acc};
    endfunction

    logic [NBLK:0]    blk_carry;
    logic [WIDTH-1:0] sum_cs;

    assign blk_carry[0] = cin;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        if (k == 0) begin : g_ripple
            assign {blk_carry[1], sum_cs[BLOCK-1:0]} =
                ripple_blk(a[BLOCK-1:0], b[BLOCK-1:0], cin);
        end else begin : g_select
            logic [BLOCK:0] r0;
            logic [BLOCK:0] r1;
            // Both carry-in hypotheses are computed in parallel; the incoming carry only drives the mux.
            assign r0 = ripple_blk(a[k*BLOCK +: BLOCK], b[k*BLOCK +: BLOCK], 1'b0);
            assign r1 = ripple_blk(a[k*BLOCK +: BLOCK], b[k*BLOCK +: BLOCK], 1'b1);
            assign sum_cs[k*BLOCK +: BLOCK] = blk_carry[k] ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
            assign blk_carry[k+1]           = blk_carry[k] ? r1[BLOCK]     : r0[BLOCK];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s    <= sum_cs;
                cout <= blk_carry[NBLK];
            end
        end
    end

`ifdef CSA_RIPPLE_CHECK_EN
    function automatic logic [WIDTH:0] ripple_full(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y,
                                                   input logic             c);
        logic [WIDTH-1:0] acc;
        logic             cc;
        cc = c;
        for (int i = 0; i < WIDTH; i++) begin
            acc[i] = x[i] ^ y[i] ^ cc;
            cc     = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
        end
        return {cc, acc};
    endfunction

    logic [WIDTH:0] ref_sum;
    assign ref_sum = ripple_full(a, b, cin);

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (in_valid) begin
            mismatch <= (ref_sum != {blk_carry[NBLK], sum_cs});
        end
    end
`endif

endmodule

// File: tb/tb_carry_select_adder_16.sv
// Scoreboard bench for carry_select_adder_16: the driver queues expected {cout,s}, a monitor pops on out_valid.
module tb_carry_select_adder_16;

    typedef struct packed {
        logic        cout;
        logic [15:0] s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic [15:0] s;
    logic        cout;
`ifdef CSA_RIPPLE_CHECK_EN
    logic        mismatch;
`endif

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    carry_select_adder_16 #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .s         (s),
        .cout      (cout)
`ifdef CSA_RIPPLE_CHECK_EN
        ,
        .mismatch  (mismatch)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one operation for the next edge and queue its expected result.
    task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         input logic [16:0] expected);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        cin      = vc;
        exp_q.push_back(exp_t'(expected));
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: samples on the falling edge, away from the capture edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", {15'd0, cout, s}, {15'd0, e.cout, e.s});
`ifdef CSA_RIPPLE_CHECK_EN
                    check("mismatch", 32'(mismatch), 32'd0);
`endif
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_s", 32'(s), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;

        // A valid op, then reset together with in_valid: the reset-cycle op must be dropped.
        issue(16'h0001, 16'h0001, 1'b1, 17'h00003);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        cin      = 1'b1;
        @(posedge clk);
        #1;
        check("rst_wins_s", 32'(s), 32'd0);
        check("rst_wins_cout", 32'(cout), 32'd0);
        check("rst_wins_out_valid", 32'(out_valid), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Directed vectors with hand-computed {cout,s}.
        issue(16'h0000, 16'h0000, 1'b0, 17'h00000);
        issue(16'h0001, 16'h0001, 1'b1, 17'h00003);
        issue(16'h7FFF, 16'h7FFF, 1'b0, 17'h0FFFE);
        issue(16'h7FFF, 16'h7FFF, 1'b1, 17'h0FFFF);
        issue(16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE);
        issue(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
        issue(16'hBFFF, 16'hBFFF, 1'b0, 17'h17FFE);
        issue(16'hBFFF, 16'hBFFF, 1'b1, 17'h17FFF);
        issue(16'h000F, 16'h0001, 1'b0, 17'h00010);
        issue(16'h0FFF, 16'h0000, 1'b1, 17'h01000);

        // Idle: out_valid drops and the last result (0x0FFF+0+1) is held.
        go_idle();
        @(posedge clk);
        #1;
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_hold_s", 32'(s), 32'h1000);
        check("idle_hold_cout", 32'(cout), 32'd0);

        // Back-to-back sweep against a 17-bit reference sum.
        for (int i = 1; i <= 199; i += 2) begin
            for (int j = 0; j <= 375; j += 3) begin
                for (int c = 0; c < 2; c++) begin
                    logic [15:0] va;
                    logic [15:0] vb;
                    logic [16:0] ref_sum;
                    va      = 16'(i + j);
                    vb      = 16'(i * j);
                    ref_sum = {1'b0, va} + {1'b0, vb} + 17'(c);
                    issue(va, vb, c[0], ref_sum);
                end
            end
        end
        go_idle();

        for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
